// File: rtl/sat_loader_pkg.sv
// sat_loader_pkg: shared types and constants for the clause array loader.
package sat_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] LIT_NONE    = 2'b00;
  localparam logic [1:0] LIT_POS     = 2'b01;
  localparam logic [1:0] LIT_NEG     = 2'b10;
  localparam logic [1:0] LIT_ILLEGAL = 2'b11;

endpackage

// File: rtl/clause_array_loader_if.sv
// clause_array_loader_if: clause streams in/out plus the write/read bus
// toward the clause array. master = loader side, slave = environment side.
interface clause_array_loader_if #(
  parameter int NUM_CLAUSES = 8,
  parameter int NUM_VARS    = 8
);
  localparam int ROW_W = 2 * NUM_VARS;

  logic [ROW_W-1:0]             clause_i;
  logic                         clause_valid_i;
  logic                         clause_ready_o;
  logic [ROW_W-1:0]             clause_o;
  logic                         clause_valid_o;
  logic                         clause_ready_i;
  logic [NUM_CLAUSES-1:0]       wr_o;
  logic [ROW_W-1:0]             lit_o;
  logic [NUM_CLAUSES*ROW_W-1:0] lit_rows_i;

  modport master (
    input  clause_i, clause_valid_i, clause_ready_i, lit_rows_i,
    output clause_ready_o, clause_o, clause_valid_o, wr_o, lit_o
  );

  modport slave (
    output clause_i, clause_valid_i, clause_ready_i, lit_rows_i,
    input  clause_ready_o, clause_o, clause_valid_o, wr_o, lit_o
  );

endinterface

// File: rtl/clause_row_mux.sv
// clause_row_mux: combinational selector picking one row out of the
// concatenated clause array read bus. Out-of-range indices give zero.
module clause_row_mux
  import sat_loader_pkg::*;
#(
  parameter int NUM_CLAUSES = 8,
  parameter int ROW_W       = 16,
  parameter int IDX_W       = 4
) (
  input  logic [NUM_CLAUSES*ROW_W-1:0] rows,
  input  logic [IDX_W-1:0]             sel,
  output logic [ROW_W-1:0]             row
);

  // Select the row whose index matches sel.
  always_comb begin
    row = {ROW_W{1'b0}};
    for (int r = 0; r < NUM_CLAUSES; r++) begin
      row = (sel == IDX_W'(r)) ? rows[r*ROW_W +: ROW_W] : row;
    end
  end

endmodule

// File: rtl/clause_array_loader.sv
// clause_array_loader: loads clause rows into the clause array (zero-filling
// the unused rows) and stores rows back out as a valid/ready stream.
// Optional build macro CLAUSE_LOADER_LIT_CHECK_EN: illegal literals (11) are
// written as absent during load and flagged on the sticky lit_err_o port.
module clause_array_loader
  import sat_loader_pkg::*;
#(
  parameter int NUM_CLAUSES = 8,
  parameter int NUM_VARS    = 8,
  parameter int WIDTH_CNT   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_load_i,
  input  logic                 start_store_i,
  input  logic [WIDTH_CNT-1:0] clause_cnt_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 cnt_err_o,
`ifdef CLAUSE_LOADER_LIT_CHECK_EN
  output logic                 lit_err_o,
`endif
  clause_array_loader_if.master bus
);

  localparam int ROW_W = 2 * NUM_VARS;
  localparam logic [WIDTH_CNT-1:0]   MAX_CNT  = WIDTH_CNT'(NUM_CLAUSES);
  localparam logic [WIDTH_CNT-1:0]   LAST_ROW = WIDTH_CNT'(NUM_CLAUSES - 1);
  localparam logic [WIDTH_CNT-1:0]   CNT_ZERO = {WIDTH_CNT{1'b0}};
  localparam logic [WIDTH_CNT-1:0]   CNT_ONE  = WIDTH_CNT'(1);
  localparam logic [ROW_W-1:0]       ROW_ZERO = {ROW_W{1'b0}};
  localparam logic [NUM_CLAUSES-1:0] WR_ZERO  = {NUM_CLAUSES{1'b0}};

  state_e               state_r;
  logic [WIDTH_CNT-1:0] row_r;
  logic [WIDTH_CNT-1:0] cnt_r;
  logic [WIDTH_CNT-1:0] cnt_sat_s;
  logic [WIDTH_CNT-1:0] row_nxt_s;
  logic [ROW_W-1:0]     mux_row_s;
  logic [ROW_W-1:0]     lit_in_s;
  logic                 accept_s;
  logic                 send_s;

  function automatic logic [NUM_CLAUSES-1:0] onehot(input logic [WIDTH_CNT-1:0] idx);
    return {{(NUM_CLAUSES-1){1'b0}}, 1'b1} << idx;
  endfunction

`ifdef CLAUSE_LOADER_LIT_CHECK_EN
  function automatic logic [ROW_W-1:0] scrub_lits(input logic [ROW_W-1:0] word);
    logic [ROW_W-1:0] res;
    res = word;
    for (int k = 0; k < NUM_VARS; k++) begin
      if (word[2*k +: 2] == LIT_ILLEGAL) begin
        res[2*k +: 2] = LIT_NONE;
      end else begin
        res[2*k +: 2] = word[2*k +: 2];
      end
    end
    return res;
  endfunction

  function automatic logic has_illegal(input logic [ROW_W-1:0] word);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < NUM_VARS; k++) begin
      bad = bad | (word[2*k +: 2] == LIT_ILLEGAL);
    end
    return bad;
  endfunction
`endif

  clause_row_mux #(
    .NUM_CLAUSES (NUM_CLAUSES),
    .ROW_W       (ROW_W),
    .IDX_W       (WIDTH_CNT)
  ) u_row_mux (
    .rows (bus.lit_rows_i),
    .sel  (row_r),
    .row  (mux_row_s)
  );

  // Saturated count, next row index, handshakes and the literal word to write.
  always_comb begin
    cnt_sat_s = (clause_cnt_i > MAX_CNT) ? MAX_CNT : clause_cnt_i;
    row_nxt_s = row_r + CNT_ONE;
    accept_s  = (state_r == ST_LOAD) && bus.clause_valid_i && bus.clause_ready_o;
    send_s    = bus.clause_valid_o && bus.clause_ready_i;
`ifdef CLAUSE_LOADER_LIT_CHECK_EN
    lit_in_s  = scrub_lits(bus.clause_i);
`else
    lit_in_s  = bus.clause_i;
`endif
  end

  // Operation sequencer: state, row/count registers and every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r            <= ST_IDLE;
      row_r              <= CNT_ZERO;
      cnt_r              <= CNT_ZERO;
      bus.wr_o           <= WR_ZERO;
      bus.lit_o          <= ROW_ZERO;
      bus.clause_o       <= ROW_ZERO;
      bus.clause_valid_o <= 1'b0;
      bus.clause_ready_o <= 1'b0;
      busy_o             <= 1'b0;
      done_o             <= 1'b0;
      cnt_err_o          <= 1'b0;
`ifdef CLAUSE_LOADER_LIT_CHECK_EN
      lit_err_o          <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle pulses unless re-armed below.
      bus.wr_o <= WR_ZERO;
      done_o   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_load_i || start_store_i) begin
            cnt_r     <= cnt_sat_s;
            row_r     <= CNT_ZERO;
            cnt_err_o <= (clause_cnt_i > MAX_CNT);
            busy_o    <= 1'b1;
`ifdef CLAUSE_LOADER_LIT_CHECK_EN
            lit_err_o <= 1'b0;
`endif
            if (start_load_i) begin
              if (cnt_sat_s == CNT_ZERO) begin
                state_r <= ST_CLEAR;
              end else begin
                state_r            <= ST_LOAD;
                bus.clause_ready_o <= 1'b1;
              end
            end else if (cnt_sat_s == CNT_ZERO) begin
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_STORE;
            end
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            bus.wr_o  <= onehot(row_r);
            bus.lit_o <= lit_in_s;
            row_r     <= row_nxt_s;
`ifdef CLAUSE_LOADER_LIT_CHECK_EN
            lit_err_o <= lit_err_o | has_illegal(bus.clause_i);
`endif
            if (row_nxt_s == cnt_r) begin
              bus.clause_ready_o <= 1'b0;
              state_r            <= (cnt_r == MAX_CNT) ? ST_DONE : ST_CLEAR;
            end
          end
        end
        ST_CLEAR: begin
          bus.wr_o  <= onehot(row_r);
          bus.lit_o <= ROW_ZERO;
          row_r     <= row_nxt_s;
          if (row_r == LAST_ROW) begin
            state_r <= ST_DONE;
          end
        end
        ST_STORE: begin
          // Output register empty (first row) or just drained: refill or finish.
          if (!bus.clause_valid_o) begin
            bus.clause_o       <= mux_row_s;
            bus.clause_valid_o <= 1'b1;
            row_r              <= row_nxt_s;
          end else if (send_s) begin
            if (row_r == cnt_r) begin
              bus.clause_valid_o <= 1'b0;
              state_r            <= ST_DONE;
            end else begin
              bus.clause_o <= mux_row_s;
              row_r        <= row_nxt_s;
            end
          end
        end
        ST_DONE: begin
          done_o  <= 1'b1;
          busy_o  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r            <= ST_IDLE;
          busy_o             <= 1'b0;
          bus.clause_ready_o <= 1'b0;
          bus.clause_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clause_array_loader.sv
// tb_clause_array_loader: table-driven and randomized self-checking bench.
// A behavioural clause array drives lit_rows_i from the observed write strobes;
// expectations come from a separate array model built from the load rules.
`timescale 1ns/1ps
module tb_clause_array_loader;
  import sat_loader_pkg::*;

  localparam int NC = 8;
  localparam int NV = 8;
  localparam int W  = 2 * NV;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_load_i;
  logic       start_store_i;
  logic [3:0] clause_cnt_i;
  logic       busy_o;
  logic       done_o;
  logic       cnt_err_o;
`ifdef CLAUSE_LOADER_LIT_CHECK_EN
  logic       lit_err_o;
`endif

  clause_array_loader_if #(.NUM_CLAUSES(NC), .NUM_VARS(NV)) bus ();

  clause_array_loader #(.NUM_CLAUSES(NC), .NUM_VARS(NV), .WIDTH_CNT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_load_i  (start_load_i),
    .start_store_i (start_store_i),
    .clause_cnt_i  (clause_cnt_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .cnt_err_o     (cnt_err_o),
`ifdef CLAUSE_LOADER_LIT_CHECK_EN
    .lit_err_o     (lit_err_o),
`endif
    .bus           (bus)
  );

  always #5 clk = ~clk;

  // Environment clause array: written by the loader's strobes.
  logic [W-1:0] arr [NC];
  always @(posedge clk) begin
    for (int r = 0; r < NC; r++) begin
      if (rst) arr[r] <= '0;
      else if (bus.wr_o[r]) arr[r] <= bus.lit_o;
    end
  end
  always_comb begin
    for (int r = 0; r < NC; r++) bus.lit_rows_i[r*W +: W] = arr[r];
  end

  // Expected array content, maintained from the specification's load rules.
  logic [W-1:0] model_mem [NC];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] scrub(input logic [W-1:0] w);
    logic [W-1:0] o;
    o = w;
`ifdef CLAUSE_LOADER_LIT_CHECK_EN
    for (int k = 0; k < NV; k++) if (w[2*k +: 2] == 2'b11) o[2*k +: 2] = 2'b00;
`endif
    return o;
  endfunction

  typedef struct {
    bit         ld;
    bit         st;
    logic [3:0] cnt;
    int         vmode;   // 0 continuous, 1 alternate cycles, 2 random
    int         rmode;   // 0 always ready, 1 stall 3 cycles on row 1, 2 random
    bit         fixed;   // words 1<<i instead of random
    bit         exp_err;
    int         exp_strobes;
    int         exp_out;
  } vec_t;

  task automatic run_op(input vec_t v);
    int n, acc, cyc, first_strobe, last_strobe, first_valid, last_hs, done_cyc, stall, valid_seen;
    bit do_load, done_seen, bad, prev_valid, prev_ready, noise_ok, vi, ri;
    logic [W-1:0] words [$];
    logic [W-1:0] exp_lit [NC];
    logic [NC-1:0] obs_wr [$];
    logic [W-1:0] obs_lit [$];
    logic [W-1:0] obs_out [$];
    logic [W-1:0] prev_data, one_w;
    logic [NC-1:0] one_r;
    one_w = 1; one_r = 1;
    n = (v.cnt > 4'd8) ? 8 : int'(v.cnt);
    do_load = v.ld;
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      words.push_back(v.fixed ? (one_w << i) : W'($urandom));
      if (scrub(words[i]) != words[i]) bad = 1'b1;
    end
    if (do_load) begin
      for (int r = 0; r < NC; r++) exp_lit[r] = (r < n) ? scrub(words[r]) : '0;
    end
    // start pulse
    start_load_i = v.ld; start_store_i = v.st; clause_cnt_i = v.cnt;
    bus.clause_valid_i = 1'($urandom_range(0, 1)); bus.clause_i = W'($urandom);
    bus.clause_ready_i = 1'b0;
    acc = 0; cyc = 0; first_strobe = -1; last_strobe = -1; first_valid = -1; last_hs = -1;
    done_cyc = -1; stall = 0; valid_seen = 0; done_seen = 0; prev_valid = 0; prev_ready = 0; prev_data = '0;
    while (!done_seen && cyc < 300) begin
      @(posedge clk); #1; cyc++;
      if (!done_o) chk("busy_high", busy_o, 1'b1);
      if (bus.wr_o != '0) begin
        chk("wr_onehot", $onehot(bus.wr_o), 1'b1);
        obs_wr.push_back(bus.wr_o); obs_lit.push_back(bus.lit_o);
        if (first_strobe < 0) first_strobe = cyc;
        last_strobe = cyc;
      end
      if (bus.clause_valid_o) begin
        valid_seen++;
        if (first_valid < 0) first_valid = cyc;
      end
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", bus.clause_valid_o, 1'b1);
        chk("hold_data", bus.clause_o, prev_data);
      end
      if (acc >= (do_load ? n : 0)) chk("ready_low", bus.clause_ready_o, 1'b0);
      if (done_o) begin done_seen = 1; done_cyc = cyc; end
      noise_ok = !done_seen && (do_load ? (acc < n) : (obs_out.size() < n));
      start_load_i  = noise_ok ? 1'($urandom_range(0, 1)) : 1'b0;
      start_store_i = noise_ok ? 1'($urandom_range(0, 1)) : 1'b0;
      clause_cnt_i  = 4'($urandom);
      if (do_load && acc < n) begin
        case (v.vmode)
          0: vi = 1'b1;
          1: vi = (cyc % 2 == 1);
          default: vi = 1'($urandom_range(0, 1));
        endcase
        bus.clause_valid_i = vi; bus.clause_i = words[acc];
        if (vi && bus.clause_ready_o) acc++;
      end else begin
        bus.clause_valid_i = 1'($urandom_range(0, 1)); bus.clause_i = W'($urandom);
      end
      case (v.rmode)
        0: ri = 1'b1;
        1: begin
          ri = !(bus.clause_valid_o && obs_out.size() == 1 && stall < 3);
          if (!ri) stall++;
        end
        default: ri = 1'($urandom_range(0, 1));
      endcase
      bus.clause_ready_i = ri;
      if (bus.clause_valid_o && ri) begin obs_out.push_back(bus.clause_o); last_hs = cyc; end
      prev_valid = bus.clause_valid_o; prev_ready = ri; prev_data = bus.clause_o;
    end
    start_load_i = 0; start_store_i = 0; bus.clause_valid_i = 0; bus.clause_ready_i = 0;
    chk("done_seen", done_seen, 1'b1);
    chk("strobe_count", obs_wr.size(), v.exp_strobes);
    if (do_load) begin
      for (int i = 0; i < obs_wr.size() && i < NC; i++) begin
        chk("strobe_wr", obs_wr[i], one_r << i);
        chk("strobe_lit", obs_lit[i], exp_lit[i]);
      end
      chk("done_after_strobe", done_cyc, last_strobe + 1);
      chk("no_valid_in_load", valid_seen, 0);
      if (v.vmode == 0) begin
        chk("first_strobe", first_strobe, 2);
        chk("last_strobe", last_strobe, 9);
      end
      for (int r = 0; r < NC; r++) model_mem[r] = exp_lit[r];
    end
    chk("out_count", obs_out.size(), v.exp_out);
    if (!do_load) begin
      for (int i = 0; i < obs_out.size() && i < NC; i++) chk("out_data", obs_out[i], model_mem[i]);
      if (n > 0) chk("first_valid", first_valid, 2);
      if (n > 0 && v.rmode == 0) chk("store_rate", last_hs, 1 + n);
    end
    chk("cnt_err", cnt_err_o, v.exp_err);
`ifdef CLAUSE_LOADER_LIT_CHECK_EN
    chk("lit_err", lit_err_o, do_load ? bad : 1'b0);
`endif
    @(posedge clk); #1;
    chk("done_pulse_end", done_o, 1'b0);
    chk("idle_after_done", busy_o, 1'b0);
  endtask

  vec_t tbl [9];
  vec_t rv;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 4'd3,  0, 0, 1'b1, 1'b0, 8, 0};
    tbl[1] = '{1'b1, 1'b0, 4'd8,  1, 0, 1'b0, 1'b0, 8, 0};
    tbl[2] = '{1'b0, 1'b1, 4'd4,  0, 1, 1'b0, 1'b0, 0, 4};
    tbl[3] = '{1'b1, 1'b1, 4'd0,  0, 0, 1'b0, 1'b0, 8, 0};
    tbl[4] = '{1'b1, 1'b0, 4'd12, 2, 0, 1'b0, 1'b1, 8, 0};
    tbl[5] = '{1'b0, 1'b1, 4'd8,  0, 2, 1'b0, 1'b0, 0, 8};
    tbl[6] = '{1'b0, 1'b1, 4'd0,  0, 0, 1'b0, 1'b0, 0, 0};
    tbl[7] = '{1'b1, 1'b0, 4'd5,  2, 0, 1'b0, 1'b0, 8, 0};
    tbl[8] = '{1'b0, 1'b1, 4'd12, 0, 0, 1'b0, 1'b1, 0, 8};
    for (int r = 0; r < NC; r++) model_mem[r] = '0;

    rst = 1'b1; start_load_i = 0; start_store_i = 0; clause_cnt_i = 4'd0;
    bus.clause_valid_i = 0; bus.clause_i = '0; bus.clause_ready_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr", bus.wr_o, 0);
    chk("rst_lit", bus.lit_o, 0);
    chk("rst_clause_o", bus.clause_o, 0);
    chk("rst_valid_o", bus.clause_valid_o, 0);
    chk("rst_ready_o", bus.clause_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_cnt_err", cnt_err_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 9; t++) run_op(tbl[t]);

    for (int t = 0; t < 12; t++) begin
      rv.ld = 1'($urandom_range(0, 1));
      rv.st = rv.ld ? 1'($urandom_range(0, 1)) : 1'b1;
      rv.cnt = 4'($urandom);
      rv.vmode = 2; rv.rmode = 2; rv.fixed = 1'b0;
      rv.exp_err = (rv.cnt > 4'd8);
      rv.exp_strobes = rv.ld ? 8 : 0;
      rv.exp_out = rv.ld ? 0 : ((rv.cnt > 4'd8) ? 8 : int'(rv.cnt));
      run_op(rv);
    end

    // Reset in the middle of a load with an over-range count.
    start_load_i = 1; clause_cnt_i = 4'd12; bus.clause_valid_i = 1; bus.clause_i = W'($urandom);
    @(posedge clk); #1;
    start_load_i = 0;
    repeat (3) begin @(posedge clk); #1; bus.clause_i = W'($urandom); end
    chk("mid_load_busy", busy_o, 1'b1);
    chk("mid_load_err", cnt_err_o, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.clause_valid_i = 0;
    chk("mid_rst_wr", bus.wr_o, 0);
    chk("mid_rst_lit", bus.lit_o, 0);
    chk("mid_rst_clause_o", bus.clause_o, 0);
    chk("mid_rst_valid_o", bus.clause_valid_o, 0);
    chk("mid_rst_ready_o", bus.clause_ready_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_done", done_o, 0);
    chk("mid_rst_cnt_err", cnt_err_o, 0);
    @(posedge clk); #1;
    chk("post_rst_idle", busy_o, 0);
    for (int r = 0; r < NC; r++) model_mem[r] = '0;

    rv = '{1'b0, 1'b1, 4'd8, 0, 0, 1'b0, 1'b0, 0, 8};
    run_op(rv);
    rv = '{1'b1, 1'b0, 4'd6, 0, 0, 1'b0, 1'b0, 8, 0};
    run_op(rv);
    rv = '{1'b0, 1'b1, 4'd6, 0, 2, 1'b0, 1'b0, 0, 6};
    run_op(rv);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
